// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Measures a slow square wave (for example a divided clock or an external
//   pulse train) against the system clock. It reports two results:
//     * frequency: rising edges counted over a fixed gate window of GATE clks
//     * period:    clk cycles between the two most recent rising edges
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   sig_in       signal under measurement, asynchronous to clk
//   enable       high = measure; low = abort any measurement and idle
//   freq         edges counted in the last completed gate window
//   freq_valid   one-cycle pulse when freq updates
//   period       clk cycles between the last two rising edges
//   period_valid one-cycle pulse when period updates
//   overflow     the value reported with the last valid pulse was saturated
//   busy         high while a gate window is in progress (enable, registered)
//
// Parameters
//   GATE   gate window length in clk cycles (must be >= 2)
//   CNT_W  width of freq/period results and of the edge/period counters
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int GATE  = 100_000_000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             busy
);

  // The gate counter only has to reach GATE-1, so it is sized from GATE
  // rather than CNT_W; a small CNT_W must not shorten the window.
  localparam int              GW        = $clog2(GATE);
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    P_IDLE,
    P_ARM,
    P_MEAS
  } pstate_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Input path: 2-flop synchronizer followed by an edge detector.
  // ---------------------------------------------------------------------------
  logic sync_d;
  logic sync_q;
  logic prev_q;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_d <= sig_in;
      sync_q <= sync_d;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

  // ---------------------------------------------------------------------------
  // Gate window and edge counter.
  // ---------------------------------------------------------------------------
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_next;
  logic             gate_done;

  // edge_next already folds in this cycle's rise, so an edge landing in the
  // terminal cycle is reported with the window that is closing.
  assign edge_next = rise ? sat_inc(edge_cnt) : edge_cnt;
  assign gate_done = enable && (gate_cnt == GATE_LAST);

  // ---------------------------------------------------------------------------
  // Period FSM (state register + combinational next state).
  // ---------------------------------------------------------------------------
  pstate_t          state;
  pstate_t          state_next;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_cnt_next;
  logic             period_done;

  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt;
    period_done     = 1'b0;
    if (!enable) begin
      state_next      = P_IDLE;
      period_cnt_next = '0;
    end else begin
      unique case (state)
        P_IDLE: begin
          state_next      = P_ARM;
          period_cnt_next = '0;
        end
        P_ARM: begin
          if (rise) begin
            state_next      = P_MEAS;
            period_cnt_next = CNT_ONE;
          end
        end
        P_MEAS: begin
          if (rise) begin
            // period_cnt already counts the current cycle, so it equals the
            // edge-to-edge distance; restart at 1 for the same reason.
            period_done     = 1'b1;
            period_cnt_next = CNT_ONE;
          end else begin
            period_cnt_next = sat_inc(period_cnt);
          end
        end
        default: begin
          state_next      = P_IDLE;
          period_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= P_IDLE;
      period_cnt <= '0;
    end else begin
      state      <= state_next;
      period_cnt <= period_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate counter, results and flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      freq         <= '0;
      freq_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;
      busy         <= enable;

      if (!enable) begin
        // Abort: discard the partial window, results keep their last values.
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (gate_done) begin
        // Next window starts right away; no dead cycle between windows.
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        freq       <= edge_next;
        freq_valid <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_next;
      end

      if (period_done) begin
        period       <= period_cnt;
        period_valid <= 1'b1;
      end

      // A result sitting at all-ones is treated as saturated. When both
      // results land in the same cycle, either one saturating sets the flag.
      if (gate_done || period_done) begin
        overflow <= (gate_done && (&edge_next)) || (period_done && (&period_cnt));
      end
    end
  end

endmodule
